xoodoo_perm_seq_sca: RTL

Sequencer that drives one instance of the first-order masked Xoodoo round, `xoodoo_round_SCA`, through a full masked permutation. The block does the following:
- accepts a 2-share state over a valid/ready handshake;
- pulls 768 bits of fresh randomness per round over a second handshake;
- supplies round constants and collects the 2-share result.

It sits between the Xoodyak cycler datapath and the round core. The shares are never recombined inside this block.

---
 rtl/xoodoo_perm_seq_sca.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/xoodoo_perm_seq_sca.sv
// Masked Xoodoo permutation sequencer with its 2-share round datapath.
// Drives the first-order masked round through NROUNDS rounds, pulling 768 fresh
// random bits per round over a valid/ready handshake. Shares are never recombined.
// Optional feature macro: XOODOO_OUT_REFRESH_EN (final output remask before DONE).
// Round datapath (xoodoo_round_SCA function, held inline):
//   s-stage: theta/rho-west/iota per share, remasked with rs1 = rs_reg[767:384].
//   D-stage: DOM chi partial products, cross-domain terms blinded with rs0 = rs_reg[383:0].
//   Output : compress D-terms per share and apply rho-east.
// State layout: lane (x, y) occupies bits [32*(4*y+x) +: 32]; plane y is [128*y +: 128].
module xoodoo_perm_seq_sca #(
  parameter int unsigned NROUNDS = 12  // legal 1..12, uses the last NROUNDS constants
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [383:0] in_0,
  input  logic [383:0] in_1,
  input  logic         rnd_valid,
  output logic         rnd_ready,
  input  logic [767:0] rnd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [383:0] out_0,
  output logic [383:0] out_1,
  output logic         busy
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StR1,
    StR2,
    StLoad,
`ifdef XOODOO_OUT_REFRESH_EN
    StRefresh,
`endif
    StDone
  } state_e;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] rc_lookup(input int unsigned idx);
    case (idx)
      0:       return 32'h0000_0058;
      1:       return 32'h0000_0038;
      2:       return 32'h0000_03C0;
      3:       return 32'h0000_00D0;
      4:       return 32'h0000_0120;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0060;
      7:       return 32'h0000_002C;
      8:       return 32'h0000_0380;
      9:       return 32'h0000_00F0;
      10:      return 32'h0000_01A0;
      11:      return 32'h0000_0012;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Linear pre-chi layer on one share: theta, rho-west, iota (rc=0 for share 1).
  function automatic logic [383:0] lin_pre(input logic [383:0] a, input logic [31:0] rc);
    logic [31:0]  l [3][4];
    logic [31:0]  p [4];
    logic [31:0]  e [4];
    logic [31:0]  t [4];
    logic [383:0] r;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) l[y][x] = a[32*(4*y+x) +: 32];
    end
    for (int x = 0; x < 4; x++) p[x] = l[0][x] ^ l[1][x] ^ l[2][x];
    for (int x = 0; x < 4; x++) e[x] = rotl32(p[(x+3)%4], 5) ^ rotl32(p[(x+3)%4], 14);
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) l[y][x] = l[y][x] ^ e[x];
    end
    for (int x = 0; x < 4; x++) t[x] = l[1][x];
    for (int x = 0; x < 4; x++) begin
      l[1][x] = t[(x+3)%4];
      l[2][x] = rotl32(l[2][x], 11);
    end
    l[0][0] = l[0][0] ^ rc;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) r[32*(4*y+x) +: 32] = l[y][x];
    end
    return r;
  endfunction

  // Post-chi rho-east on one share.
  function automatic logic [383:0] rho_east(input logic [383:0] a);
    logic [31:0]  l [3][4];
    logic [31:0]  t [4];
    logic [383:0] r;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) l[y][x] = a[32*(4*y+x) +: 32];
    end
    for (int x = 0; x < 4; x++) t[x] = l[2][x];
    for (int x = 0; x < 4; x++) begin
      l[1][x] = rotl32(l[1][x], 1);
      l[2][x] = rotl32(t[(x+2)%4], 8);
    end
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) r[32*(4*y+x) +: 32] = l[y][x];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Sequencer registers
  // ---------------------------------------------------------------------------
  state_e       r_state;
  state_e       w_state_nxt;
  logic [383:0] r_st_0, r_st_1;
  logic [383:0] w_st_0_nxt, w_st_1_nxt;
  logic [767:0] r_rs;
  logic [767:0] w_rs_nxt;
  logic [3:0]   r_rc_idx;
  logic [3:0]   w_rc_idx_nxt;
  logic [31:0]  w_rconst;

  // ---------------------------------------------------------------------------
  // Round datapath registers
  // ---------------------------------------------------------------------------
  logic [383:0] r_s0, r_s1;
  logic [383:0] r_d0, r_d1, r_c0, r_c1;
  logic [383:0] w_d0, w_d1, w_c0, w_c1;
  logic [383:0] w_rnd_out0, w_rnd_out1;

  assign w_rconst = rc_lookup(12 - NROUNDS + 32'(r_rc_idx));

  // DOM chi: same-domain terms stay in their share, cross terms get blinded by rs0.
  always_comb begin
    w_d0 = '0;
    w_d1 = '0;
    w_c0 = '0;
    w_c1 = '0;
    for (int y = 0; y < 3; y++) begin
      w_d0[128*y +: 128] = r_s0[128*y +: 128] ^
                           (~r_s0[128*((y+1)%3) +: 128] & r_s0[128*((y+2)%3) +: 128]);
      w_d1[128*y +: 128] = r_s1[128*y +: 128] ^
                           (r_s1[128*((y+1)%3) +: 128] & r_s1[128*((y+2)%3) +: 128]);
      w_c0[128*y +: 128] = (~r_s0[128*((y+1)%3) +: 128] & r_s1[128*((y+2)%3) +: 128]) ^
                           r_rs[128*y +: 128];
      w_c1[128*y +: 128] = (r_s1[128*((y+1)%3) +: 128] & r_s0[128*((y+2)%3) +: 128]) ^
                           r_rs[128*y +: 128];
    end
  end

  // Round outputs: per-share compression of the registered D-terms.
  always_comb begin
    w_rnd_out0 = rho_east(r_d0 ^ r_c0);
    w_rnd_out1 = rho_east(r_d1 ^ r_c1);
  end

  // Round registers update every cycle; only R1/R2/LOAD-edge samples are used.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= '0;
      r_s1 <= '0;
      r_d0 <= '0;
      r_d1 <= '0;
      r_c0 <= '0;
      r_c1 <= '0;
    end else begin
      r_s0 <= lin_pre(r_st_0, w_rconst) ^ r_rs[767:384];
      r_s1 <= lin_pre(r_st_1, 32'h0) ^ r_rs[767:384];
      r_d0 <= w_d0;
      r_d1 <= w_d1;
      r_c0 <= w_c0;
      r_c1 <= w_c1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_st_0   <= '0;
      r_st_1   <= '0;
      r_rs     <= '0;
      r_rc_idx <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_st_0   <= w_st_0_nxt;
      r_st_1   <= w_st_1_nxt;
      r_rs     <= w_rs_nxt;
      r_rc_idx <= w_rc_idx_nxt;
    end
  end

  // Next-state and handshake outputs; all outputs held quiet while rst is high.
  always_comb begin
    w_state_nxt  = r_state;
    w_st_0_nxt   = r_st_0;
    w_st_1_nxt   = r_st_1;
    w_rs_nxt     = r_rs;
    w_rc_idx_nxt = r_rc_idx;
    in_ready     = 1'b0;
    rnd_ready    = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_st_0_nxt   = in_0;
          w_st_1_nxt   = in_1;
          w_rc_idx_nxt = '0;
          w_state_nxt  = StFetch;
        end
      end
      StFetch: begin
        rnd_ready = 1'b1;
        if (rnd_valid) begin
          w_rs_nxt    = rnd;
          w_state_nxt = StR1;
        end
      end
      StR1: w_state_nxt = StR2;
      StR2: w_state_nxt = StLoad;
      StLoad: begin
        w_st_0_nxt = w_rnd_out0;
        w_st_1_nxt = w_rnd_out1;
        if (r_rc_idx < 4'(NROUNDS - 1)) begin
          w_rc_idx_nxt = r_rc_idx + 4'd1;
          rnd_ready    = 1'b1;
          if (rnd_valid) begin
            w_rs_nxt    = rnd;
            w_state_nxt = StR1;
          end else begin
            w_state_nxt = StFetch;
          end
        end else begin
`ifdef XOODOO_OUT_REFRESH_EN
          w_state_nxt = StRefresh;
`else
          w_state_nxt = StDone;
`endif
        end
      end
`ifdef XOODOO_OUT_REFRESH_EN
      StRefresh: begin
        rnd_ready = 1'b1;
        // Same mask on both shares: unmasked value unchanged; upper half discarded.
        if (rnd_valid) begin
          w_st_0_nxt  = r_st_0 ^ rnd[383:0];
          w_st_1_nxt  = r_st_1 ^ rnd[383:0];
          w_state_nxt = StDone;
        end
      end
`endif
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_st_0_nxt  = '0;
          w_st_1_nxt  = '0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      rnd_ready = 1'b0;
      out_valid = 1'b0;
    end
  end

  // Result shares are exposed only while out_valid is high.
  always_comb begin
    out_0 = out_valid ? r_st_0 : '0;
    out_1 = out_valid ? r_st_1 : '0;
    busy  = (r_state != StIdle) && !rst;
  end

endmodule
